execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Pipeline execute stage; consumes the decode/execute pipe outputs (operands, extended immediate, ALU control, condition field, flag-write mask, control bits, destination register) and produces the execute/memory pipe register.
- Contains operand-B select, a 32-bit ALU, the NZCV flags register, and ARM condition evaluation that gates register/memory/flag/branch side effects.
- Also returns the current flags to decode and a combinational branch-taken/target to fetch.

Parameters:
- WIDTH, 32, datapath width.
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stallE  in  1  hold E/M register and flags.
- flushE  in  1  squash the instruction currently in E.
- RD1E  in  WIDTH  operand A.
- RD2E  in  WIDTH  register operand B / store data.
- ExtImmE  in  WIDTH  extended immediate.
- ALUSrcE  in  1  1 = B from ExtImmE, 0 = from RD2E.
- ALUControlE  in  4  ALU op (exe_pkg encoding).
- PlusOneE  in  1  carry-in = 1 for ADD.
- CondE  in  4  ARM condition field.
- FlagWriteE  in  2  [1] updates N,Z; [0] updates C,V.
- RegWriteE, MemWriteE, MemToRegE, BranchE, PCSrcE  in  1 each  control bits.
- WA3E  in  4  destination register.
- ALUResultM  out  WIDTH  registered ALU result.
- WriteDataM  out  WIDTH  registered store data (post-forwarding RD2).
- WA3M  out  4  registered destination register.
- RegWriteM, MemWriteM, MemToRegM, PCSrcM  out  1 each  registered, condition-gated.
- FlagsE  out  4  current flags register {N,Z,C,V}.
- CondExE  out  1  combinational condition result.
- BranchTakenE  out  1  combinational BranchE & CondExE & ~flushE.
- ALUResultE  out  WIDTH  combinational ALU result (branch target).

Behaviour:
- Reset (reset=0, asynchronous): all M outputs = 0; FlagsE = RESET_FLAGS. Takes effect mid-operation immediately; the instruction in flight is lost.
- Latency: one cycle from E inputs to M outputs. ALUResultE, CondExE and BranchTakenE are same-cycle combinational.
- SrcB = ALUSrcE ? ExtImmE : RD2E.
- ALU ops:
  - 0000 ADD: A+B+PlusOneE.
  - 0001 SUB: A-B.
  - 0010 AND.
  - 0011 ORR.
  - 0100 EOR.
  - 0101 MOV: B.
  - 0110 MVN: ~B.
  - 0111 LSL: A << B[4:0].
  - 1000 LSR: A >> B[4:0].
  - 1001 CMP: SUB, forces RegWrite off.
  - Others: ADD.
- Flags from a WIDTH+1 sum:
  - N = result[MSB]; Z = result==0.
  - C = carry-out for ADD/SUB/CMP (SUB carry = no-borrow), else unchanged-value passthrough.
  - V = signed overflow for ADD/SUB/CMP, else passthrough.
- Condition codes (standard ARM): EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL. 1111 evaluates false. Evaluated against FlagsE before this instruction's update.
- Flag update at clock edge: N,Z written iff FlagWriteE[1] & CondExE & ~stallE & ~flushE; C,V likewise with FlagWriteE[0].
- E/M register update:
  - stallE=1: hold all M outputs and flags.
  - flushE=1: load bubble (all M control bits 0, data don't-care but driven 0).
  - Else: load results; RegWriteM = RegWriteE & CondExE & op≠CMP; MemWriteM = MemWriteE & CondExE; PCSrcM = PCSrcE & CondExE; MemToRegM = MemToRegE.
- Simultaneous stallE & flushE: flush wins (bubble loaded, flags held).
- Back-to-back flag setter then conditional instruction: the second instruction sees the updated flags (register written at the intervening edge).

Optional Feature:
- Macro EXE_FORWARD_EN.
- Defined: adds ports ForwardAE[1:0], ForwardBE[1:0] and ResultW[WIDTH]. Operand A/RD2 source per forward select: 00 register, 01 ResultW, 10 ALUResultM, 11 register. The forwarded RD2 feeds both SrcB mux and WriteDataM.
- Undefined: ports absent; operands taken directly from RD1E/RD2E.

Decomposition:
- Package exe_pkg: alu_op_e enum (4-bit codes above), cond_e enum, flag index constants N=3 Z=2 C=1 V=0, flags_t typedef.
- Sub-module exe_cond_check: CondE + FlagsE -> CondExE, purely combinational.
- ALU, flags register and E/M register live in execute_stage.

Test Plan:
- Reset with FlagsE=4'b1111 state, assert reset=0 mid-cycle -> all M outputs 0, FlagsE=0000 immediately.
- SUB A=5 B=5, FlagWriteE=11, CondE=AL -> ALUResultM=0, next FlagsE=0110 (Z=1, C=1). Following ADD with CondE=EQ -> RegWriteM=1; with CondE=NE -> RegWriteM=0, flags unchanged.
- ADD A=0x7FFFFFFF B=1 FlagWriteE=11 -> result 0x80000000, FlagsE=1001. ADD PlusOneE=1 A=1 B=1 -> 3.
- stallE=1 for 2 cycles with changing inputs -> M outputs and FlagsE constant. stallE=flushE=1 -> bubble, flags held.
- BranchE=1 CondE=AL ALUSrcE=1 ExtImmE=0x100 RD1E=0x08 -> BranchTakenE=1 and ALUResultE=0x108 same cycle. CondE=1111 -> BranchTakenE=0.
- (EXE_FORWARD_EN) ForwardAE=10 with ALUResultM=0x20, RD1E=0 ADD B=1 -> 0x21. ForwardBE=01, ResultW=0xAB, MemWriteE=1 -> WriteDataM=0xAB.

Source files
------------

// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exe_pkg
//  Description : Shared types for the execute stage: ALU op codes, ARM
//                condition codes, NZCV flag bit positions and flag type.
//  Revision    : 1.0  initial release
// ============================================================================
package exe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_ORR = 4'b0011,
    ALU_EOR = 4'b0100,
    ALU_MOV = 4'b0101,
    ALU_MVN = 4'b0110,
    ALU_LSL = 4'b0111,
    ALU_LSR = 4'b1000,
    ALU_CMP = 4'b1001
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage
`default_nettype wire

// File: rtl/exe_cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : exe_cond_check
//  Description : ARM condition evaluation of a 4-bit condition field against
//                the current NZCV flags. Purely combinational; 1111 is false.
//  Revision    : 1.0  initial release
// ============================================================================
module exe_cond_check
  import exe_pkg::*;
(
  input  logic [3:0] i_cond,
  input  flags_t     i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  // Decode the condition field into a single pass/fail bit
  always_comb begin
    o_cond_ex = 1'b0;
    case (cond_e'(i_cond))
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = (w_n == w_v);
      COND_LT: o_cond_ex = (w_n != w_v);
      COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ex = w_z | (w_n != w_v);
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : Pipeline execute stage: operand-B select, 32-bit ALU, NZCV
//                flags register, condition gating of side effects and the
//                execute/memory pipe register. Branch target and taken flag
//                are returned combinationally to fetch.
//                Build option EXE_FORWARD_EN adds operand forwarding ports.
//  Revision    : 1.0  initial release
// ============================================================================
module execute_stage
  import exe_pkg::*;
#(
  parameter int         WIDTH       = 32,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ExtImmE,
  input  logic             ALUSrcE,
  input  logic [3:0]       ALUControlE,
  input  logic             PlusOneE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemToRegE,
  input  logic             BranchE,
  input  logic             PCSrcE,
  input  logic [3:0]       WA3E,
`ifdef EXE_FORWARD_EN
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
`endif
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       WA3M,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemToRegM,
  output logic             PCSrcM,
  output logic [3:0]       FlagsE,
  output logic             CondExE,
  output logic             BranchTakenE,
  output logic [WIDTH-1:0] ALUResultE
);

  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  logic [3:0]       wa3_q, wa3_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             pc_src_q, pc_src_d;
  flags_t           flags_q, flags_d;

  logic [WIDTH-1:0] w_src_a, w_rd2, w_src_b, w_b_adj, w_result;
  logic [WIDTH:0]   w_sum;
  logic             w_is_sub, w_cin, w_arith, w_carry, w_ovf, w_fire;
  alu_op_e          w_op;

`ifdef EXE_FORWARD_EN
  // Forwarding muxes for operand A and the register B / store-data path
  always_comb begin
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = alu_result_q;
      default: w_src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   w_rd2 = ResultW;
      2'b10:   w_rd2 = alu_result_q;
      default: w_rd2 = RD2E;
    endcase
  end
`else
  assign w_src_a = RD1E;
  assign w_rd2   = RD2E;
`endif

  assign w_src_b = ALUSrcE ? ExtImmE : w_rd2;
  assign w_op    = alu_op_e'(ALUControlE);

  // Shared adder: subtraction is A + ~B + 1 so carry-out is the no-borrow flag
  always_comb begin
    w_is_sub = (w_op == ALU_SUB) || (w_op == ALU_CMP);
    w_b_adj  = w_is_sub ? ~w_src_b : w_src_b;
    w_cin    = w_is_sub ? 1'b1 : PlusOneE;
    w_sum    = {1'b0, w_src_a} + {1'b0, w_b_adj} + {{WIDTH{1'b0}}, w_cin};
    w_carry  = w_sum[WIDTH];
    w_ovf    = (w_src_a[WIDTH-1] == w_b_adj[WIDTH-1]) &&
               (w_sum[WIDTH-1] != w_src_a[WIDTH-1]);
  end

  // ALU result select; unlisted codes fall back to ADD, including flags
  always_comb begin
    w_arith  = 1'b0;
    w_result = w_sum[WIDTH-1:0];
    case (w_op)
      ALU_AND: w_result = w_src_a & w_src_b;
      ALU_ORR: w_result = w_src_a | w_src_b;
      ALU_EOR: w_result = w_src_a ^ w_src_b;
      ALU_MOV: w_result = w_src_b;
      ALU_MVN: w_result = ~w_src_b;
      ALU_LSL: w_result = w_src_a << w_src_b[4:0];
      ALU_LSR: w_result = w_src_a >> w_src_b[4:0];
      default: w_arith  = 1'b1;
    endcase
  end

  exe_cond_check u_cond_check (
    .i_cond    (CondE),
    .i_flags   (flags_q),
    .o_cond_ex (CondExE)
  );

  assign ALUResultE   = w_result;
  assign BranchTakenE = BranchE & CondExE & ~flushE;
  assign w_fire       = CondExE & ~stallE & ~flushE;

  // Next flags: only a retiring, condition-passed instruction may write them
  always_comb begin
    flags_d = flags_q;
    if (FlagWriteE[1] && w_fire) begin
      flags_d[FLAG_N] = w_result[WIDTH-1];
      flags_d[FLAG_Z] = (w_result == '0);
    end
    if (FlagWriteE[0] && w_fire) begin
      flags_d[FLAG_C] = w_arith ? w_carry : flags_q[FLAG_C];
      flags_d[FLAG_V] = w_arith ? w_ovf   : flags_q[FLAG_V];
    end
  end

  // Next E/M contents: flush beats stall, stall holds, otherwise load
  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    wa3_d        = wa3_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    pc_src_d     = pc_src_q;
    if (flushE) begin
      alu_result_d = '0;
      write_data_d = '0;
      wa3_d        = '0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      pc_src_d     = 1'b0;
    end else if (!stallE) begin
      alu_result_d = w_result;
      write_data_d = w_rd2;
      wa3_d        = WA3E;
      reg_write_d  = RegWriteE & CondExE & (w_op != ALU_CMP);
      mem_write_d  = MemWriteE & CondExE;
      mem_to_reg_d = MemToRegE;
      pc_src_d     = PCSrcE & CondExE;
    end
  end

  // E/M pipe register and flags register with asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      wa3_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_src_q     <= 1'b0;
      flags_q      <= RESET_FLAGS;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      pc_src_q     <= pc_src_d;
      flags_q      <= flags_d;
    end
  end

  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign WA3M       = wa3_q;
  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign MemToRegM  = mem_to_reg_q;
  assign PCSrcM     = pc_src_q;
  assign FlagsE     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Self-checking bench for execute_stage: directed steps from
//                the test plan followed by randomized instructions compared
//                against a behavioural model of the execute stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallE, flushE;
  logic [31:0] RD1E, RD2E, ExtImmE;
  logic        ALUSrcE, PlusOneE;
  logic [3:0]  ALUControlE, CondE, WA3E;
  logic [1:0]  FlagWriteE;
  logic        RegWriteE, MemWriteE, MemToRegE, BranchE, PCSrcE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic [31:0] ALUResultM, WriteDataM, ALUResultE;
  logic [3:0]  WA3M, FlagsE;
  logic        RegWriteM, MemWriteM, MemToRegM, PCSrcM, CondExE, BranchTakenE;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [3:0]  m_flags;
  logic [31:0] m_res, m_wd;
  logic [3:0]  m_wa3;
  logic        m_rw, m_mw, m_mtr, m_pcs;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(32), .RESET_FLAGS(4'b0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stallE       (stallE),
    .flushE       (flushE),
    .RD1E         (RD1E),
    .RD2E         (RD2E),
    .ExtImmE      (ExtImmE),
    .ALUSrcE      (ALUSrcE),
    .ALUControlE  (ALUControlE),
    .PlusOneE     (PlusOneE),
    .CondE        (CondE),
    .FlagWriteE   (FlagWriteE),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .MemToRegE    (MemToRegE),
    .BranchE      (BranchE),
    .PCSrcE       (PCSrcE),
    .WA3E         (WA3E),
`ifdef EXE_FORWARD_EN
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .ResultW      (ResultW),
`endif
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .WA3M         (WA3M),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .MemToRegM    (MemToRegM),
    .PCSrcM       (PCSrcM),
    .FlagsE       (FlagsE),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .ALUResultE   (ALUResultE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ARM condition truth table written from the flag meanings
  function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Integer-arithmetic ALU model; nf is the full candidate {N,Z,C,V}
  task automatic alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic p, input logic [3:0] f,
                           output logic [31:0] r, output logic [3:0] nf);
    longint          sa, sb, ss;
    longint unsigned ua, ub;
    logic            c, v;
    logic [4:0]      sh;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    sh = b[4:0];
    c = f[1]; v = f[0];
    case (op)
      4'd1, 4'd9: begin
        r  = a - b;
        c  = (ua >= ub);
        ss = sa - sb;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = b;
      4'd6: r = ~b;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      default: begin
        r  = a + b + {31'd0, p};
        c  = (ua + ub + longint'(p)) > 64'h0000_0000_FFFF_FFFF;
        ss = sa + sb + longint'(p);
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
    endcase
    nf = {r[31], (r == 32'd0), c, v};
  endtask

  task automatic chk_seq();
    chk("alu_m",   ALUResultM, m_res);
    chk("wdata_m", WriteDataM, m_wd);
    chk("wa3_m",   {28'd0, WA3M}, {28'd0, m_wa3});
    chk("rw_m",    {31'd0, RegWriteM}, {31'd0, m_rw});
    chk("mw_m",    {31'd0, MemWriteM}, {31'd0, m_mw});
    chk("mtr_m",   {31'd0, MemToRegM}, {31'd0, m_mtr});
    chk("pcs_m",   {31'd0, PCSrcM}, {31'd0, m_pcs});
    chk("flags",   {28'd0, FlagsE}, {28'd0, m_flags});
  endtask

  task automatic model_reset();
    m_flags = 4'b0000; m_res = '0; m_wd = '0; m_wa3 = '0;
    m_rw = 0; m_mw = 0; m_mtr = 0; m_pcs = 0;
  endtask

  // One instruction: check combinational outputs, clock it, check M and flags
  task automatic step();
    logic [31:0] r, b;
    logic [3:0]  nf;
    logic        ce;
    b  = ALUSrcE ? ExtImmE : RD2E;
    alu_model(ALUControlE, RD1E, b, PlusOneE, m_flags, r, nf);
    ce = cond_model(CondE, m_flags);
    #1;
    chk("alu_e",    ALUResultE, r);
    chk("condex",   {31'd0, CondExE}, {31'd0, ce});
    chk("br_taken", {31'd0, BranchTakenE}, {31'd0, BranchE & ce & ~flushE});
    @(posedge clk);
    if (flushE) begin
      m_res = '0; m_wd = '0; m_wa3 = '0; m_rw = 0; m_mw = 0; m_mtr = 0; m_pcs = 0;
    end else if (!stallE) begin
      m_res = r; m_wd = RD2E; m_wa3 = WA3E;
      m_rw  = RegWriteE && ce && (ALUControlE != 4'd9);
      m_mw  = MemWriteE && ce;
      m_mtr = MemToRegE;
      m_pcs = PCSrcE && ce;
      if (ce && FlagWriteE[1]) m_flags[3:2] = nf[3:2];
      if (ce && FlagWriteE[0]) m_flags[1:0] = nf[1:0];
    end
    #1;
    chk_seq();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] cc, input logic [1:0] fw, input logic rw, input logic p);
    ALUControlE = op; RD1E = a; RD2E = b; ExtImmE = 32'h0; ALUSrcE = 0;
    CondE = cc; FlagWriteE = fw; RegWriteE = rw; PlusOneE = p;
    MemWriteE = 0; MemToRegE = 0; BranchE = 0; PCSrcE = 0; WA3E = 4'd3;
    stallE = 0; flushE = 0;
  endtask

  task automatic rand_op();
    RD1E        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
    case ($urandom_range(0, 3))
      0:       RD2E = RD1E;
      1:       RD2E = 32'($urandom_range(0, 40));
      default: RD2E = $urandom;
    endcase
    ExtImmE     = ($urandom_range(0, 1) == 0) ? RD1E : $urandom;
    ALUSrcE     = 1'($urandom);
    ALUControlE = 4'($urandom);
    PlusOneE    = 1'($urandom);
    CondE       = 4'($urandom);
    FlagWriteE  = 2'($urandom);
    RegWriteE   = 1'($urandom);
    MemWriteE   = 1'($urandom);
    MemToRegE   = 1'($urandom);
    BranchE     = 1'($urandom);
    PCSrcE      = 1'($urandom);
    WA3E        = 4'($urandom);
    stallE      = ($urandom_range(0, 7) == 0);
    flushE      = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'h0;
    set_op(4'd0, 0, 0, 4'd14, 2'b00, 0, 0);
    reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_seq();
    chk("rst_flags", {28'd0, FlagsE}, 32'h0);
    reset = 1;
    @(negedge clk);

    // SUB 5-5 sets Z and C
    set_op(4'd1, 32'd5, 32'd5, 4'd14, 2'b11, 1, 0);
    step();
    chk("sub_res",   ALUResultM, 32'h0);
    chk("sub_flags", {28'd0, FlagsE}, 32'h6);

    // EQ passes, NE fails and leaves flags alone
    set_op(4'd0, 32'd1, 32'd2, 4'd0, 2'b00, 1, 0);
    step();
    chk("eq_rw", {31'd0, RegWriteM}, 32'h1);
    set_op(4'd0, 32'd1, 32'd2, 4'd1, 2'b11, 1, 0);
    step();
    chk("ne_rw",    {31'd0, RegWriteM}, 32'h0);
    chk("ne_flags", {28'd0, FlagsE}, 32'h6);

    // Signed overflow into the sign bit
    set_op(4'd0, 32'h7FFF_FFFF, 32'd1, 4'd14, 2'b11, 1, 0);
    step();
    chk("ovf_res",   ALUResultM, 32'h8000_0000);
    chk("ovf_flags", {28'd0, FlagsE}, 32'h9);

    // ADD with carry-in forced
    set_op(4'd0, 32'd1, 32'd1, 4'd14, 2'b00, 1, 1);
    step();
    chk("plus1_res", ALUResultM, 32'd3);

    // Two stalled cycles with changing inputs
    for (int i = 0; i < 2; i++) begin
      rand_op();
      stallE = 1; flushE = 0;
      step();
      chk("stall_res",   ALUResultM, 32'd3);
      chk("stall_flags", {28'd0, FlagsE}, 32'h9);
    end

    // Stall plus flush: bubble, flags held
    set_op(4'd1, 32'd9, 32'd9, 4'd14, 2'b11, 1, 0);
    MemWriteE = 1; stallE = 1; flushE = 1;
    step();
    chk("sf_rw",    {31'd0, RegWriteM}, 32'h0);
    chk("sf_flags", {28'd0, FlagsE}, 32'h9);

    // Branch target and taken, same cycle
    set_op(4'd0, 32'h08, 32'h0, 4'd14, 2'b00, 0, 0);
    BranchE = 1; ALUSrcE = 1; ExtImmE = 32'h100;
    #1;
    chk("br_tgt",   ALUResultE, 32'h108);
    chk("br_taken1", {31'd0, BranchTakenE}, 32'h1);
    step();
    set_op(4'd0, 32'h08, 32'h0, 4'd15, 2'b00, 0, 0);
    BranchE = 1; ALUSrcE = 1; ExtImmE = 32'h100;
    #1;
    chk("br_nv", {31'd0, BranchTakenE}, 32'h0);
    step();

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      rand_op();
      step();
    end

    // Asynchronous reset in the middle of a cycle
    set_op(4'd0, 32'h7FFF_FFFF, 32'd1, 4'd14, 2'b11, 1, 0);
    step();
    rand_op();
    #3;
    reset = 0;
    #1;
    model_reset();
    chk_seq();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 20; i++) begin
      rand_op();
      step();
    end

`ifdef EXE_FORWARD_EN
    set_op(4'd5, 32'h0, 32'h0, 4'd14, 2'b00, 0, 0);
    ALUSrcE = 1; ExtImmE = 32'h20;
    step();
    set_op(4'd0, 32'h0, 32'h55, 4'd14, 2'b00, 1, 0);
    ALUSrcE = 1; ExtImmE = 32'h1; ForwardAE = 2'b10;
    ForwardBE = 2'b01; ResultW = 32'hAB; MemWriteE = 1;
    #1;
    chk("fwd_a", ALUResultE, 32'h21);
    @(posedge clk);
    #1;
    chk("fwd_res", ALUResultM, 32'h21);
    chk("fwd_wd",  WriteDataM, 32'hAB);
    chk("fwd_mw",  {31'd0, MemWriteM}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
